fix_field_tokenizer: RTL

//  Streaming FIX tag=value tokenizer. Takes an ASCII byte stream, one byte per cycle, under valid/ready.

---
 rtl/fix_pkg.sv | 31 +++
 rtl/fix_checksum_acc.sv | 71 +++++++
 rtl/fix_field_tokenizer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fix_pkg.sv
// Shared constants, state encoding and field record for the FIX tokenizer.
// The top module fix_field_tokenizer has an optional checksum feature, selected by the FIX_CHECKSUM_EN macro.
package fix_pkg;

    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    localparam int unsigned TAG_BEGIN_STRING = 8;
    localparam int unsigned TAG_CHECKSUM     = 10;

    typedef enum logic [1:0] {TAG, VALUE, SKIP} tok_state_e;

    // Field record at the default tokenizer widths, for consumers such as message storage
    localparam int unsigned FIELD_TAG_W       = 32;
    localparam int unsigned FIELD_VALUE_BYTES = 32;
    localparam int unsigned FIELD_LEN_W       = $clog2(FIELD_VALUE_BYTES + 1);

    typedef struct packed {
        logic [FIELD_TAG_W-1:0]         tag;
        logic [8*FIELD_VALUE_BYTES-1:0] value;
        logic [FIELD_LEN_W-1:0]         len;
        logic                           trunc;
        logic                           err;
    } fix_field_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/fix_checksum_acc.sv
// Mod-256 field/message byte sums and decimal compare against a checksum field value.
module fix_checksum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        emit,
    input  logic        is_begin,
    input  logic        is_cs,
    input  logic [23:0] value_hi,
    input  logic [1:0]  value_len,
    output logic        ok_c
);
    import fix_pkg::*;

    logic [7:0] sum_field;
    logic [7:0] sum_msg;
    logic [7:0] sum_next;
    logic [9:0] dec;
    logic       digits_ok;
    logic [7:0] b0, b1, b2;

    assign sum_next = sum_field + byte_data;
    assign b0 = value_hi[23:16];
    assign b1 = value_hi[15:8];
    assign b2 = value_hi[7:0];

    // The emitting delimiter belongs to the field it closes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_field <= 8'd0;
            sum_msg   <= 8'd0;
        end else if (byte_valid) begin
            if (emit) begin
                sum_field <= 8'd0;
                if (is_begin)
                    sum_msg <= sum_next;
                else if (!is_cs)
                    sum_msg <= sum_msg + sum_next;
            end else begin
                sum_field <= sum_next;
            end
        end
    end

    always_comb begin
        dec       = 10'd0;
        digits_ok = 1'b0;
        case (value_len)
            2'd1: begin
                digits_ok = is_digit(b0);
                dec       = 10'(b0[3:0]);
            end
            2'd2: begin
                digits_ok = is_digit(b0) && is_digit(b1);
                dec       = 10'(b0[3:0]) * 10'd10 + 10'(b1[3:0]);
            end
            2'd3: begin
                digits_ok = is_digit(b0) && is_digit(b1) && is_digit(b2);
                dec       = 10'(b0[3:0]) * 10'd100 + 10'(b1[3:0]) * 10'd10 + 10'(b2[3:0]);
            end
            default: begin
                digits_ok = 1'b0;
                dec       = 10'd0;
            end
        endcase
    end

    assign ok_c = is_cs && digits_ok && (dec == 10'(sum_msg));

endmodule

// File: rtl/fix_field_tokenizer.sv
// Streaming FIX tag=value tokenizer: bytes in, one decoded field per handshake out.
// Optional checksum verification is built when FIX_CHECKSUM_EN is defined.
module fix_field_tokenizer
    import fix_pkg::*;
#(
    parameter int unsigned VALUE_BYTES = 32,
    parameter int unsigned TAG_W       = 32,
    parameter logic [7:0]  DELIM       = 8'h7C,
    parameter int unsigned MSG_CNT_W   = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       data_i,
    input  logic                             data_valid_i,
    output logic                             data_ready_o,
    output logic                             field_valid_o,
    input  logic                             field_ready_i,
    output logic [TAG_W-1:0]                 tag_o,
    output logic [8*VALUE_BYTES-1:0]         value_o,
    output logic [$clog2(VALUE_BYTES+1)-1:0] value_len_o,
    output logic                             value_trunc_o,
    output logic                             field_err_o,
    output logic                             start_of_header_o,
    output logic                             end_of_msg_o,
    output logic                             checksum_ok_o,
    output logic [MSG_CNT_W-1:0]             msg_count_o
);
    localparam int unsigned VAL_W  = 8 * VALUE_BYTES;
    localparam int unsigned LEN_W  = $clog2(VALUE_BYTES + 1);
    localparam int unsigned PROD_W = TAG_W + 4;

    tok_state_e        state, state_n;
    logic [TAG_W-1:0]  tag_q, tag_n;
    logic [VAL_W-1:0]  val_q, val_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic              digits_q, digits_n;
    logic              err_q, err_n;
    logic              trunc_q, trunc_n;
    logic              accept, is_delim, emit, emit_err;
    logic              is_bs_c, is_cs_c;
    logic [PROD_W-1:0] prod;

    assign data_ready_o = !(field_valid_o && !field_ready_i);
    assign accept       = data_valid_i && data_ready_o;
    assign is_delim     = (data_i == DELIM);
    assign prod         = PROD_W'(tag_q) * PROD_W'(10) + PROD_W'(data_i[3:0]);
    assign emit_err     = err_q || (state != VALUE);
    assign is_bs_c      = !emit_err && (tag_q == TAG_W'(TAG_BEGIN_STRING));
    assign is_cs_c      = !emit_err && (tag_q == TAG_W'(TAG_CHECKSUM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TAG;
        else     state <= state_n;
    end

    // Next state and field accumulators; emit restarts a fresh field
    always_comb begin
        state_n  = state;
        tag_n    = tag_q;
        val_n    = val_q;
        len_n    = len_q;
        digits_n = digits_q;
        err_n    = err_q;
        trunc_n  = trunc_q;
        emit     = 1'b0;
        if (accept) begin
            case (state)
                TAG: begin
                    if (is_delim) begin
                        emit = digits_q;
                    end else if (is_digit(data_i)) begin
                        tag_n    = prod[TAG_W-1:0];
                        digits_n = 1'b1;
                        if (prod[PROD_W-1:TAG_W] != 4'd0) err_n = 1'b1;
                    end else if (data_i == CH_EQ) begin
                        state_n = VALUE;
                        if (!digits_q) err_n = 1'b1;
                    end else begin
                        err_n   = 1'b1;
                        state_n = SKIP;
                    end
                end
                VALUE: begin
                    if (is_delim) begin
                        emit = 1'b1;
                    end else if (len_q < LEN_W'(VALUE_BYTES)) begin
                        val_n[VAL_W-1-8*32'(len_q) -: 8] = data_i;
                        len_n = len_q + LEN_W'(1);
                    end else begin
                        trunc_n = 1'b1;
                    end
                end
                SKIP: begin
                    if (is_delim) emit = 1'b1;
                end
                default: state_n = TAG;
            endcase
        end
        if (emit) begin
            state_n  = TAG;
            tag_n    = '0;
            val_n    = '0;
            len_n    = '0;
            digits_n = 1'b0;
            err_n    = 1'b0;
            trunc_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= '0;
            val_q    <= '0;
            len_q    <= '0;
            digits_q <= 1'b0;
            err_q    <= 1'b0;
            trunc_q  <= 1'b0;
        end else begin
            tag_q    <= tag_n;
            val_q    <= val_n;
            len_q    <= len_n;
            digits_q <= digits_n;
            err_q    <= err_n;
            trunc_q  <= trunc_n;
        end
    end

    // Output register: a new field may load in the same cycle the old one is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_valid_o     <= 1'b0;
            tag_o             <= '0;
            value_o           <= '0;
            value_len_o       <= '0;
            value_trunc_o     <= 1'b0;
            field_err_o       <= 1'b0;
            start_of_header_o <= 1'b0;
            end_of_msg_o      <= 1'b0;
            msg_count_o       <= '0;
        end else begin
            if (field_valid_o && field_ready_i && end_of_msg_o)
                msg_count_o <= msg_count_o + MSG_CNT_W'(1);
            if (emit) begin
                field_valid_o     <= 1'b1;
                tag_o             <= tag_q;
                value_o           <= val_q;
                value_len_o       <= len_q;
                value_trunc_o     <= trunc_q;
                field_err_o       <= emit_err;
                start_of_header_o <= is_bs_c;
                end_of_msg_o      <= is_cs_c;
            end else if (field_ready_i) begin
                field_valid_o <= 1'b0;
            end
        end
    end

`ifdef FIX_CHECKSUM_EN
    logic       cs_ok_c;
    logic [1:0] cs_len;

    // Only 1..3 stored, untruncated digits can encode a checksum
    assign cs_len = (!trunc_q && len_q != '0 && len_q <= LEN_W'(3)) ? 2'(len_q) : 2'd0;

    fix_checksum_acc u_checksum_acc (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept),
        .byte_data  (data_i),
        .emit       (emit),
        .is_begin   (is_bs_c),
        .is_cs      (is_cs_c),
        .value_hi   (val_q[VAL_W-1 -: 24]),
        .value_len  (cs_len),
        .ok_c       (cs_ok_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       checksum_ok_o <= 1'b0;
        else if (emit) checksum_ok_o <= cs_ok_c;
    end
`else
    assign checksum_ok_o = 1'b1;
`endif

endmodule
